corefifo_gray_bin_pipe: RTL and testbench

Parametrised, pipelined, bidirectional Gray/binary code converter with a valid/ready handshake on both sides. It is the next generation of the FIFO pointer converter. It gives configurable latency for timing closure at wide pointer widths, selects direction per item, and runs a sticky integrity check that flags illegal multi-bit Gray transitions. It sits on the read/write pointer paths of the FIFO after the CDC synchronisers, and ahead of the full/empty and level logic.

---
 rtl/corefifo_gray_bin_pipe.sv | 163 ++++++++++++++++
 tb/tb_corefifo_gray_bin_pipe.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/corefifo_gray_bin_pipe.sv
// Pipelined Gray<->binary pointer converter with valid/ready handshake,
// per-item direction select and a sticky illegal-Gray-transition detector.
module corefifo_gray_bin_pipe #(
  parameter int ADDRWIDTH   = 3,
  parameter int PIPE_STAGES = 2,
  parameter int MODE        = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               dir_in,
  input  logic [ADDRWIDTH:0] data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDRWIDTH:0] data_out,
  output logic               gray_err,
  input  logic               err_clr
);
  localparam int unsigned W = ADDRWIDTH + 1;
  localparam int unsigned S = PIPE_STAGES;

  // Exclusive top bit of slice k; slices run MSB-first, wider ones first.
  function automatic int unsigned slice_top(input int unsigned k);
    int unsigned top;
    top = W;
    for (int unsigned j = 0; j < k; j++) begin
      top = top - (W / S) - ((j < (W % S)) ? 32'd1 : 32'd0);
    end
    return top;
  endfunction

  logic [S-1:0] vld_q;
  logic [W-1:0] data_q  [S];
  logic         dir_q   [S];
  logic         carry_q [S];

  logic [S-1:0] vld_d;
  logic [W-1:0] data_d  [S];
  logic         dir_d   [S];
  logic         carry_d [S];
  logic [S-1:0] load;
  logic         dir_eff;

  always_comb begin
    if (MODE == 0) begin
      dir_eff = 1'b0;
    end else if (MODE == 1) begin
      dir_eff = 1'b1;
    end else begin
      dir_eff = dir_in;
    end
  end

  // A stage may load unless it and every stage after it are full and stalled.
  always_comb begin
    logic full_run;
    full_run = 1'b1;
    load     = '0;
    for (int unsigned j = 0; j < S; j++) begin
      full_run        = full_run & vld_q[S-1-j];
      load[S-1-j]     = !full_run | out_ready;
    end
  end

  assign in_ready = load[0] & !reset;

  // Carry is the converted bit above the slice for Gray->bin, the raw bit for bin->Gray.
  always_comb begin
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         c;
    for (int unsigned k = 0; k < S; k++) begin
      if (k == 0) begin
        din      = data_in;
        dir_d[k] = dir_eff;
        c        = 1'b0;
        vld_d[k] = in_valid;
      end else begin
        din      = data_q[k-1];
        dir_d[k] = dir_q[k-1];
        c        = carry_q[k-1];
        vld_d[k] = vld_q[k-1];
      end
      dout = din;
      for (int unsigned j = 0; j < W; j++) begin
        if (((W - 1 - j) < slice_top(k)) && ((W - 1 - j) >= slice_top(k + 1))) begin
          dout[W-1-j] = din[W-1-j] ^ c;
          c           = dir_d[k] ? din[W-1-j] : dout[W-1-j];
        end
      end
      data_d[k]  = dout;
      carry_d[k] = c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int unsigned k = 0; k < S; k++) begin
        data_q[k]  <= '0;
        dir_q[k]   <= 1'b0;
        carry_q[k] <= 1'b0;
      end
    end else begin
      for (int unsigned k = 0; k < S; k++) begin
        if (load[k]) begin
          vld_q[k] <= vld_d[k];
          if (vld_d[k]) begin
            data_q[k]  <= data_d[k];
            dir_q[k]   <= dir_d[k];
            carry_q[k] <= carry_d[k];
          end
        end
      end
    end
  end

  assign out_valid = vld_q[S-1];
  assign data_out  = data_q[S-1];

  logic [W-1:0] hist_q, hist_d, diff;
  logic         hist_vld_q, hist_vld_d;
  logic         err_q, err_d;
  logic         gray_acc;

  // diff & (diff-1) is nonzero exactly when more than one bit changed.
  always_comb begin
    gray_acc   = in_valid & in_ready & !dir_eff;
    diff       = data_in ^ hist_q;
    err_d      = err_q;
    hist_d     = hist_q;
    hist_vld_d = hist_vld_q;
    if (gray_acc) begin
      hist_d     = data_in;
      hist_vld_d = 1'b1;
      if (hist_vld_q && ((diff & (diff - 1'b1)) != '0)) begin
        err_d = 1'b1;
      end
    end
    if (err_clr) begin
      err_d = 1'b0;
      if (!gray_acc) begin
        hist_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q     <= '0;
      hist_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      hist_q     <= hist_d;
      hist_vld_q <= hist_vld_d;
      err_q      <= err_d;
    end
  end

  assign gray_err = err_q;

endmodule

// File: tb/tb_corefifo_gray_bin_pipe.sv
// Scoreboard bench for corefifo_gray_bin_pipe: directed cases plus random
// traffic checked against a behavioural conversion and Gray-check model.
module tb_corefifo_gray_bin_pipe;
  localparam int AW = 3;
  localparam int S  = 2;
  localparam int W  = AW + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic         dir_in;
  logic [W-1:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] data_out;
  logic         gray_err;
  logic         err_clr;

  corefifo_gray_bin_pipe #(
    .ADDRWIDTH  (AW),
    .PIPE_STAGES(S),
    .MODE       (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dir_in   (dir_in),
    .data_in  (data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .gray_err (gray_err),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];
  logic         m_err, m_hv;
  logic [W-1:0] m_hist;
  logic         prev_stall;
  logic [W-1:0] prev_data;

  function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int unsigned i = 0; i < W; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  function automatic logic [W-1:0] ref_b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Acceptance tracker: pushes expected results and advances the Gray-check model.
  always @(negedge clk) begin
    logic [W-1:0] d;
    logic         gacc;
    if (!reset) begin
      check("gray_err", gray_err, m_err);
      gacc = 1'b0;
      if (in_valid && in_ready) begin
        d = data_in;
        exp_q.push_back(dir_in ? ref_b2g(d) : ref_g2b(d));
        if (!dir_in) begin
          gacc = 1'b1;
          if (m_hv && ($countones(d ^ m_hist) > 1)) m_err = 1'b1;
          m_hist = d;
          m_hv   = 1'b1;
        end
      end
      if (err_clr) begin
        m_err = 1'b0;
        if (!gacc) m_hv = 1'b0;
      end
    end
  end

  // Output monitor: pops and compares on every transfer, checks hold under stall.
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", data_out, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out: actual=%0h required=none at %0t", data_out, $time);
        end else begin
          check("data_out", data_out, exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = data_out;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int unsigned n = 0; n < 20 && (exp_q.size() != 0 || out_valid); n++) step();
    check("drained", exp_q.size(), 0);
  endtask

  task automatic latency_probe(input logic dr, input logic [W-1:0] d,
                               input logic [W-1:0] want, input string name);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    dir_in    = dr;
    data_in   = d;
    check({name, "_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({name, "_latency"}, lat, S);
    check({name, "_data"}, data_out, want);
  endtask

  initial begin
    int unsigned acc;
    logic [W-1:0] lastg;
    reset = 1'b1; in_valid = 1'b0; dir_in = 1'b0; data_in = '0;
    out_ready = 1'b0; err_clr = 1'b0;
    m_err = 1'b0; m_hv = 1'b0; m_hist = '0; prev_stall = 1'b0; prev_data = '0;
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_gray_err", gray_err, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1 check("rel_in_ready", in_ready, 1);
    step();

    latency_probe(1'b0, 4'b1101, 4'b1001, "g2b");
    drain();
    latency_probe(1'b1, 4'b1001, 4'b1101, "b2g");
    drain();

    out_ready = 1'b1; in_valid = 1'b1; dir_in = 1'b0; data_in = 4'b0110;
    step();
    dir_in = 1'b1;
    step();
    in_valid = 1'b0;
    check("mixed0_valid", out_valid, 1);
    check("mixed0_data", data_out, 4'b0100);
    step();
    check("mixed1_valid", out_valid, 1);
    check("mixed1_data", data_out, 4'b0101);
    drain();

    err_clr = 1'b1; step(); err_clr = 1'b0;
    in_valid = 1'b1; dir_in = 1'b0;
    for (int unsigned i = 0; i < 17; i++) begin
      data_in = ref_b2g(i[W-1:0]);
      check("stream_ready", in_ready, 1);
      if (i >= S) check("stream_out_valid", out_valid, 1);
      step();
    end
    in_valid = 1'b0;
    drain();
    check("stream_err", gray_err, 0);

    out_ready = 1'b0; in_valid = 1'b1; acc = 0;
    for (int unsigned i = 0; i < 5; i++) begin
      dir_in  = 1'($urandom);
      data_in = W'($urandom);
      if (in_ready) acc++;
      step();
    end
    check("bp_accepted", acc, S);
    check("bp_in_ready", in_ready, 0);
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_drain0", out_valid, 1);
    step();
    check("bp_drain1", out_valid, 1);
    step();
    check("bp_empty", out_valid, 0);
    drain();

    err_clr = 1'b1; step(); err_clr = 1'b0;
    in_valid = 1'b1; dir_in = 1'b0; data_in = 4'b0000;
    step();
    data_in = 4'b0011;
    step();
    in_valid = 1'b0;
    check("gerr_set", gray_err, 1);
    repeat (10) step();
    check("gerr_sticky", gray_err, 1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("gerr_clr", gray_err, 0);
    in_valid = 1'b1; data_in = 4'b0011;
    step();
    data_in = 4'b0010;
    step();
    in_valid = 1'b0;
    step();
    check("gerr_legal", gray_err, 0);
    drain();

    lastg = '0;
    for (int unsigned i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      dir_in    = 1'($urandom);
      err_clr   = ($urandom % 32) == 0;
      if ($urandom % 5 == 0) data_in = W'($urandom);
      else if ($urandom % 6 == 0) data_in = lastg;
      else data_in = lastg ^ (W'(1) << $urandom_range(0, W - 1));
      lastg = data_in;
      step();
    end
    err_clr = 1'b0;
    drain();

    out_ready = 1'b0; in_valid = 1'b1; dir_in = 1'b0; data_in = 4'b0000; err_clr = 1'b1;
    step();
    err_clr = 1'b0; data_in = 4'b0011;
    step();
    in_valid = 1'b0;
    check("pre_rst_err", gray_err, 1);
    check("pre_rst_valid", out_valid, 1);
    #1 reset = 1'b1;
    exp_q.delete();
    m_err = 1'b0; m_hv = 1'b0; prev_stall = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_data_out", data_out, 0);
    check("mid_rst_gray_err", gray_err, 0);
    check("mid_rst_in_ready", in_ready, 0);
    reset = 1'b0;
    #1 check("post_rst_in_ready", in_ready, 1);
    out_ready = 1'b1; in_valid = 1'b1; dir_in = 1'b0; data_in = 4'b1100;
    step();
    data_in = 4'b1101;
    step();
    in_valid = 1'b0;
    step();
    check("post_rst_unchecked", gray_err, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: actual=timeout required=finish at %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
